bp_be_branch_resolver: RTL

- Consumer end of the integer pipe's branch-result interface.
- Takes each resolved branch outcome (taken flag, next PC, misaligned flag) and compares the next PC with the PC the frontend predicted.
- On a mispredict or misaligned target, holds a registered redirect command toward the frontend command path until it is accepted.
- Keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/bp_be_branch_resolver_if.sv | 55 +++++
 rtl/bp_be_branch_resolver.sv | 114 +++++++++++
 2 files changed

// File: rtl/bp_be_branch_resolver_if.sv
// -----------------------------------------------------------------------------
// bp_be_branch_resolver_if
//   Bundle between the integer pipe / frontend command path and the branch
//   resolver. Carries the resolved-branch result, the redirect command with its
//   yumi handshake, and the performance counters.
//
//   Parameters
//     vaddr_width_p : virtual address width of npc / pred_npc / redirect_npc
//     ctr_width_p   : width of each saturating performance counter
//
//   Modports
//     master : pipe/frontend side. Drives the result and redirect_yumi_i, and
//              observes ready, the redirect command and the counters.
//     slave  : resolver side (the opposite directions).
// -----------------------------------------------------------------------------
interface bp_be_branch_resolver_if #(
   parameter int vaddr_width_p = 39,
   parameter int ctr_width_p   = 32
);
   // Resolved branch result from the integer pipe
   logic                     v_i;
   logic                     branch_i;
   logic                     btaken_i;
   logic [vaddr_width_p-1:0] npc_i;
   logic [vaddr_width_p-1:0] pred_npc_i;
   logic                     instr_misaligned_v_i;
   logic                     flush_i;
   logic                     ready_o;

   // Redirect command toward the frontend
   logic                     redirect_v_o;
   logic [vaddr_width_p-1:0] redirect_npc_o;
   logic                     redirect_taken_o;
   logic                     redirect_misaligned_o;
   logic                     redirect_yumi_i;
   logic                     mispredict_o;

   // Performance monitoring
   logic [ctr_width_p-1:0]   branch_cnt_o;
   logic [ctr_width_p-1:0]   mispredict_cnt_o;

   modport master (
      output v_i, branch_i, btaken_i, npc_i, pred_npc_i,
             instr_misaligned_v_i, flush_i, redirect_yumi_i,
      input  ready_o, redirect_v_o, redirect_npc_o, redirect_taken_o,
             redirect_misaligned_o, mispredict_o, branch_cnt_o, mispredict_cnt_o
   );

   modport slave (
      input  v_i, branch_i, btaken_i, npc_i, pred_npc_i,
             instr_misaligned_v_i, flush_i, redirect_yumi_i,
      output ready_o, redirect_v_o, redirect_npc_o, redirect_taken_o,
             redirect_misaligned_o, mispredict_o, branch_cnt_o, mispredict_cnt_o
   );
endinterface

// File: rtl/bp_be_branch_resolver.sv
// -----------------------------------------------------------------------------
// bp_be_branch_resolver
//   Consumer end of the integer pipe's branch-result interface. Compares each
//   resolved next PC against the frontend's prediction; on a mispredict or a
//   misaligned target it raises a registered redirect command and holds it
//   until the frontend takes it (redirect_yumi_i) or the pipe is flushed.
//   Saturating branch / mispredict counters are kept for perf monitoring.
//
//   Ports
//     clk_i   : clock, all state on the rising edge
//     reset_i : asynchronous, active-high reset
//     bus     : bp_be_branch_resolver_if.slave
//               in  : v_i, branch_i, btaken_i, npc_i, pred_npc_i,
//                     instr_misaligned_v_i, flush_i, redirect_yumi_i
//               out : ready_o, redirect_v_o, redirect_npc_o, redirect_taken_o,
//                     redirect_misaligned_o, mispredict_o,
//                     branch_cnt_o, mispredict_cnt_o
// -----------------------------------------------------------------------------
module bp_be_branch_resolver #(
   parameter int vaddr_width_p = 39,
   parameter int ctr_width_p   = 32
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   bp_be_branch_resolver_if.slave    bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e                   state;
   logic                     redirect_v;
   logic [vaddr_width_p-1:0] redirect_npc;
   logic                     redirect_taken;
   logic                     redirect_misaligned;
   logic                     mispredict;
   logic [ctr_width_p-1:0]   branch_cnt;
   logic [ctr_width_p-1:0]   mispredict_cnt;

   logic resolve;
   logic mis;

   // Anything presented while HOLD is wrong-path and is neither captured nor
   // counted; a flush also kills the result in the same cycle.
   assign resolve = bus.v_i & bus.branch_i & (state == RUN) & ~bus.flush_i;
   assign mis     = (bus.npc_i != bus.pred_npc_i);

   // NOTE: ready is a plain continuous assign of the state, so no latch can be
   // inferred and it reacts to an asynchronous reset without a clock.
   assign bus.ready_o = (state == RUN);

   // NOTE: every register here, payload included, is reset; the payload is a
   // handful of flops, not a memory, and a known value keeps the outputs clean.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state               <= RUN;
         redirect_v          <= 1'b0;
         redirect_npc        <= '0;
         redirect_taken      <= 1'b0;
         redirect_misaligned <= 1'b0;
         mispredict          <= 1'b0;
         branch_cnt          <= '0;
         mispredict_cnt      <= '0;
      end else begin
         // NOTE: non-blocking assignments only, so every register samples the
         // pre-edge value of every other register regardless of order.
         mispredict <= 1'b0;   // one-cycle pulse

         if (bus.flush_i) begin
            // Flush wins over yumi and over any new result.
            state      <= RUN;
            redirect_v <= 1'b0;
         end else begin
            unique case (state)
               RUN: begin
                  if (resolve && (bus.instr_misaligned_v_i || mis)) begin
                     state               <= HOLD;
                     redirect_v          <= 1'b1;
                     redirect_npc        <= bus.npc_i;
                     redirect_taken      <= bus.btaken_i;
                     redirect_misaligned <= bus.instr_misaligned_v_i;
                     mispredict          <= 1'b1;
                  end
               end
               HOLD: begin
                  if (bus.redirect_yumi_i) begin
                     state      <= RUN;
                     redirect_v <= 1'b0;
                  end
               end
               default: state <= RUN;
            endcase
         end

         if (resolve) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
            // A misaligned target is an exception, not a mispredict.
            if (mis && !bus.instr_misaligned_v_i && (mispredict_cnt != '1))
               mispredict_cnt <= mispredict_cnt + 1'b1;
         end
      end
   end

   assign bus.redirect_v_o          = redirect_v;
   assign bus.redirect_npc_o        = redirect_npc;
   assign bus.redirect_taken_o      = redirect_taken;
   assign bus.redirect_misaligned_o = redirect_misaligned;
   assign bus.mispredict_o          = mispredict;
   assign bus.branch_cnt_o          = branch_cnt;
   assign bus.mispredict_cnt_o      = mispredict_cnt;

endmodule
